fetch_stage: RTL

Parametrised instruction-fetch stage for the SCC core, replacing the fixed-width, always-increment PC register. It generates sequential fetch addresses from a configurable reset vector, accepts redirects (branch/jump targets) from later stages, and talks to instruction memory through a request/response handshake with variable latency. Fetched instructions are buffered together with their PC in a small FIFO and handed to decode through a valid/ready interface.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the SCC instruction-fetch stage: entry layout,
// PC step and counter-width helpers.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int PC_STEP    = DEF_DATA_W / 8;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] data;
  } fetch_entry_t;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int pc_step(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush, simultaneous push/pop and an
// occupancy count. The head entry is read straight from the storage registers.
module fetch_fifo import fetch_pkg::*; #(
  parameter int               WIDTH     = 64,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      valid,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  // Flush wins over a same-cycle pop; a push on a full buffer is only legal
  // together with a pop, where the slot being written is the one read out.
  assign do_pop = pop && (count != '0) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequential PC generation, redirects, variable-latency
// memory handshake with bounded outstanding requests, and a {pc,data} buffer.
module fetch_stage import fetch_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int                OW   = cnt_w(MAX_OUT);
  localparam int                CW   = cnt_w(DEPTH);
  localparam int                SW   = cnt_w(DEPTH + MAX_OUT);
  localparam int                EW   = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(pc_step(DATA_W));

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     discard;
  logic [CW-1:0]     count;
  logic [SW-1:0]     credit;
  logic              accepted;
  logic              rsp_ok;
  logic              drop;
  logic              push;
  logic [EW-1:0]     head;

  // Handshakes: a memory request transfers on imem_req && imem_ready; an
  // instruction transfers to decode on inst_valid && inst_ready; a valid
  // output holds its payload stable until the transfer happens.
  // Issue depends only on registered state plus halt/redirect, so there is
  // no path from inst_ready to imem_req.
  assign credit   = SW'(count) + SW'(outstanding) - SW'(discard);
  assign imem_req = !reset && !halt && !redirect_valid &&
                    (outstanding < OW'(MAX_OUT)) && (credit < SW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accepted  = imem_req && imem_ready;

  // A response with nothing outstanding is ignored so the counter stays at 0.
  assign rsp_ok = imem_rvalid && (outstanding != '0);
  assign drop   = rsp_ok && (discard != '0);
  assign push   = rsp_ok && (discard == '0) && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      // Every request still in flight after this cycle belongs to the old path.
      outstanding <= outstanding - OW'(rsp_ok);
      discard     <= outstanding - OW'(rsp_ok);
    end else begin
      if (accepted) fetch_pc <= fetch_pc + STEP;
      if (push)     resp_pc  <= resp_pc + STEP;
      outstanding <= outstanding + OW'(accepted) - OW'(rsp_ok);
      if (drop) discard <= discard - OW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH     (EW),
    .DEPTH     (DEPTH),
    .RESET_VAL ({RESET_PC, {DATA_W{1'b0}}})
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({resp_pc, imem_rdata}),
    .pop   (inst_valid && inst_ready),
    .rdata (head),
    .valid (inst_valid),
    .count (count)
  );

  assign {inst_pc, inst_data} = head;

  rsp_without_request : assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (outstanding == '0)))
    else $error("fetch_stage: imem_rvalid with no outstanding request");

endmodule
